hb_channel_scheduler: RTL and testbench
=======================================

# hb_channel_scheduler

Time-multiplexing controller that shares one halfband multiply-accumulate datapath among all PDM microphone channels. Each channel's CIC decimator raises a one-cycle request when a new sample is ready. The scheduler queues these requests, grants channels round-robin, and sequences the shared MAC through every tap of the selected channel. It then reports which channel's result is valid, replacing the per-channel naive-multiplier halfband instances.

## Interface

Parameters:
- NCH, 20, number of channels (requesters), ≥2
- NTAPS, 11, MAC steps per output sample, ≥2
- LAT, 2, MAC pipeline latency, from last step issued to result valid, 1..NTAPS
- CW, $clog2(NCH), channel index width (derived)
- TW, $clog2(NTAPS), tap index width (derived)

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- req  input  NCH  per-channel new-sample pulse, one cycle wide
- mac_stall  input  1  shared MAC cannot accept a step this cycle
- ch_sel  output  CW  channel in service; indexes the sample buffers
- tap_idx  output  TW  tap in service; indexes the coefficient ROM and sample delay line
- mac_en  output  1  step issued this cycle
- mac_clr  output  1  first step of a job; the MAC loads instead of accumulating
- mac_last  output  1  final step of a job
- out_valid  output  1  one-cycle pulse; MAC result for out_ch is valid
- out_ch  output  CW  channel of the current result
- overrun  output  1  one-cycle pulse; a request was dropped
- overrun_ch  output  CW  channel whose request was dropped
- busy  output  1  FSM in RUN or any pending bit set

## Operation

- pending[NCH-1:0] register: bit set by req[i], cleared when channel i is granted.
  - If set and clear hit the same bit in the same cycle, set wins. No overrun is reported.
  - req[i] while pending[i] is already set (and not being cleared): the request is dropped. overrun pulses next cycle with overrun_ch=i.
  - If several channels overrun in one cycle, report the lowest index. The others are dropped silently.
  - A req for the channel currently in service sets its pending bit normally, because that bit was cleared at grant.
- Round-robin pointer rr (CW bits, reset 0). Grant goes to the first pending channel at index ≥ rr, wrapping modulo NCH. After the grant, rr = granted+1, wrapping NCH-1 → 0.
- FSM states:
  - IDLE:
    - mac_en=0.
    - If any pending bit is set: grant, latch ch_sel, tap_idx=0, go to RUN.
    - Otherwise stay in IDLE.
  - RUN:
    - mac_en = !mac_stall.
    - mac_clr = mac_en && tap_idx==0.
    - mac_last = mac_en && tap_idx==NTAPS-1.
    - On an accepted step (mac_en), tap_idx increments.
    - On an accepted last step: tap_idx returns to 0 and the FSM goes to IDLE.
    - During a stall, ch_sel and tap_idx hold.
- Completion pipeline: an LAT-deep shift register of {valid, ch}, loaded with {1, ch_sel} on mac_last. Its output drives out_valid and out_ch.
- ch_sel, tap_idx and out_ch hold their last value when the matching strobe is low.

## Timing

- Reset (asynchronous, rst=0): all outputs 0, pending=0, rr=0, FSM=IDLE, completion pipeline cleared. This applies mid-job too: the job is abandoned and no out_valid is produced.
- First cycle after rst deasserts: the FSM may grant if req was sampled on that same edge. That req is captured on the first active edge.
- Latency with no stall:
  - req high in cycle 0 → pending visible cycle 1 → grant at end of cycle 1.
  - mac_en and mac_clr high in cycle 2.
  - mac_last in cycle 2+NTAPS-1.
  - out_valid in cycle 2+NTAPS-1+LAT.
- Throughput: one job per NTAPS+1 cycles (one IDLE cycle between jobs). NCH·(NTAPS+1) must not exceed the CIC output period; the integrator guarantees this.
- Each stall cycle extends the job by exactly one cycle. out_valid is still LAT cycles after mac_last.
- Stall in IDLE has no effect. The grant proceeds and the stall applies in RUN.

## Test plan

- Single request: NCH=20, NTAPS=11, LAT=2, req[3] in cycle 0 → ch_sel=3; mac_clr cycle 2; tap_idx 0..10 over cycles 2..12; mac_last cycle 12; out_valid cycle 14 with out_ch=3; busy low from cycle 13.
- All channels at once: req=all-ones in cycle 0 → grants in order 0,1,…,19, each mac_clr 12 cycles apart; 20 out_valid pulses with out_ch 0..19; no overrun.
- Round-robin fairness: serve ch5, then assert req[2] and req[7] together → ch7 granted before ch2; rr wraps after ch19 → ch0.
- Overrun and set-wins:
  - req[4] twice before ch4 is granted → overrun pulse, overrun_ch=4, exactly one job for ch4.
  - req[4] in ch4's grant cycle → no overrun, and a second ch4 job follows.
- Stall: assert mac_stall during tap_idx=5 for 3 cycles → tap_idx holds at 5, mac_en low for 3 cycles, mac_last and out_valid each delayed by exactly 3 cycles.
- Reset mid-job: pull rst low at tap_idx=6 with pending {1,9} → all outputs 0 immediately, no out_valid. After release, req[9] is granted first, from rr=0 with only ch9 pending.

Source files
------------

// File: rtl/hb_channel_scheduler.sv
// hb_channel_scheduler
//   Shares one halfband MAC datapath among NCH decimator channels. Each
//   channel posts a one-cycle sample-ready pulse; pulses are queued as
//   pending bits and served round-robin. A granted job issues NTAPS MAC
//   steps (stall-aware). The finished channel is reported LAT cycles after
//   the last step.
//
// Ports
//   clk, rst       clock, async active-low reset
//   req[NCH]       per-channel new-sample pulse
//   mac_stall      MAC cannot take a step this cycle
//   ch_sel, tap_idx  channel / tap in service (hold when idle or stalled)
//   mac_en, mac_clr, mac_last  step strobes: issue, first step, final step
//   out_valid, out_ch  result-ready pulse and its channel
//   overrun, overrun_ch  dropped-request pulse and its channel (lowest index)
//   busy           a job is running or any request is pending

// One pending bit. Set wins over the grant clear, so a request landing on
// the grant cycle queues the next job rather than being lost.
module hb_pend_cell (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic clr,
  output logic pend,
  output logic drop
);
  // Only a request hitting a bit that stays set is lost.
  assign drop = req & pend & ~clr;

  always_ff @(posedge clk or negedge rst)
    if (!rst) pend <= 1'b0;
    else      pend <= req | (pend & ~clr);
endmodule

module hb_channel_scheduler #(
  parameter int NCH   = 20,
  parameter int NTAPS = 11,
  parameter int LAT   = 2,
  parameter int CW    = $clog2(NCH),
  parameter int TW    = $clog2(NTAPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NCH-1:0] req,
  input  logic          mac_stall,
  output logic [CW-1:0] ch_sel,
  output logic [TW-1:0] tap_idx,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          mac_last,
  output logic          out_valid,
  output logic [CW-1:0] out_ch,
  output logic          overrun,
  output logic [CW-1:0] overrun_ch,
  output logic          busy
);
  localparam logic [TW-1:0] TAP_LAST = TW'(NTAPS-1);
  localparam logic [CW-1:0] CH_LAST  = CW'(NCH-1);
  localparam int            STAGES   = LAT-1;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic [NCH-1:0] pending, drop, clr;
  logic [CW-1:0]  rr, gnt_ch, ov_ch;
  logic           gnt_any, gnt, ov_any;

  // ---------------------------------------------------------------------
  // Pending bits, one cell per channel
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < NCH; i++) begin : g_pend
    hb_pend_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .req  (req[i]),
      .clr  (clr[i]),
      .pend (pending[i]),
      .drop (drop[i])
    );
  end

  // ---------------------------------------------------------------------
  // Round-robin search: first pending channel at rr, rr+1, ... mod NCH
  // ---------------------------------------------------------------------
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_ch  = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(rr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!gnt_any && pending[CW'(idx)]) begin
        gnt_any = 1'b1;
        gnt_ch  = CW'(idx);
      end
    end
  end

  // Grants only happen from IDLE.
  assign gnt = (state == IDLE) && gnt_any;
  assign clr = gnt ? ({{(NCH-1){1'b0}}, 1'b1} << gnt_ch) : '0;

  // Lowest-index dropped request; scanning downward lets the lowest win.
  always_comb begin
    ov_any = 1'b0;
    ov_ch  = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      if (drop[i]) begin
        ov_any = 1'b1;
        ov_ch  = CW'(i);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Job FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nxt;

  always_comb begin
    state_nxt = state;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    mac_last  = 1'b0;
    case (state)
      IDLE: if (gnt_any) state_nxt = RUN;
      RUN: begin
        mac_en   = !mac_stall;
        mac_clr  = mac_en && (tap_idx == '0);
        mac_last = mac_en && (tap_idx == TAP_LAST);
        if (mac_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Channel select, tap counter, rr pointer, overrun report
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ch_sel     <= '0;
      tap_idx    <= '0;
      rr         <= '0;
      overrun    <= 1'b0;
      overrun_ch <= '0;
    end else begin
      if (gnt) begin
        ch_sel  <= gnt_ch;
        tap_idx <= '0;
        rr      <= (gnt_ch == CH_LAST) ? '0 : gnt_ch + CW'(1);
      end else if (mac_en) begin
        tap_idx <= mac_last ? '0 : tap_idx + TW'(1);
      end
      overrun <= ov_any;
      if (ov_any) overrun_ch <= ov_ch;
    end

  // ---------------------------------------------------------------------
  // Completion pipeline: LAT stages of {valid, ch}. The channel field only
  // advances with a valid entry, so out_ch holds between results.
  // ---------------------------------------------------------------------
  logic [STAGES:0]         vld_pipe;
  logic [STAGES:0][CW-1:0] ch_pipe;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      vld_pipe <= '0;
      ch_pipe  <= '0;
    end else begin
      vld_pipe[0] <= mac_last;
      if (mac_last) ch_pipe[0] <= ch_sel;
      for (int k = 1; k <= STAGES; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        if (vld_pipe[k-1]) ch_pipe[k] <= ch_pipe[k-1];
      end
    end

  assign out_valid = vld_pipe[STAGES];
  assign out_ch    = ch_pipe[STAGES];
  assign busy      = (state == RUN) || (|pending);

endmodule

// File: tb/tb_hb_channel_scheduler.sv
// Directed bench for hb_channel_scheduler (NCH=20, NTAPS=11, LAT=2).
// A negedge monitor logs step/result/overrun events with cycle stamps;
// each scenario then compares the log against hand-derived cycle offsets.
module tb_hb_channel_scheduler;
  localparam int NCH = 20, NTAPS = 11, LAT = 2;
  localparam int CW = $clog2(NCH), TW = $clog2(NTAPS);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] req = '0;
  logic           mac_stall = 1'b0;
  logic [CW-1:0]  ch_sel, out_ch, overrun_ch;
  logic [TW-1:0]  tap_idx;
  logic           mac_en, mac_clr, mac_last, out_valid, overrun, busy;

  hb_channel_scheduler #(.NCH(NCH), .NTAPS(NTAPS), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .mac_stall(mac_stall),
    .ch_sel(ch_sel), .tap_idx(tap_idx), .mac_en(mac_en), .mac_clr(mac_clr),
    .mac_last(mac_last), .out_valid(out_valid), .out_ch(out_ch),
    .overrun(overrun), .overrun_ch(overrun_ch), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0, nfail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, $signed(got), $signed(exp), cyc);
    end
  endtask

  // ---------------- event monitor ----------------
  int clr_c[$], clr_ch[$], last_c[$], ov_c[$], ov_ch[$], or_c[$], or_ch[$];
  int busy_last = 0, tap_err = 0, en_cnt = 0, exp_tap = 0;

  always @(negedge clk) begin
    if (!rst) begin
      exp_tap <= 0;
    end else begin
      if (busy) busy_last <= cyc;
      if (mac_en) begin
        en_cnt  <= en_cnt + 1;
        tap_err <= tap_err + ((int'(tap_idx) != exp_tap) ? 1 : 0)
                           + ((mac_clr  != (exp_tap == 0))       ? 1 : 0)
                           + ((mac_last != (exp_tap == NTAPS-1)) ? 1 : 0);
        exp_tap <= mac_last ? 0 : exp_tap + 1;
        if (mac_clr) begin clr_c.push_back(cyc); clr_ch.push_back(int'(ch_sel)); end
        if (mac_last) last_c.push_back(cyc);
      end else if (mac_clr || mac_last) begin
        tap_err <= tap_err + 1;
      end
      if (out_valid) begin ov_c.push_back(cyc); ov_ch.push_back(int'(out_ch)); end
      if (overrun)   begin or_c.push_back(cyc); or_ch.push_back(int'(overrun_ch)); end
    end
  end

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic clear_q();
    clr_c.delete(); clr_ch.delete(); last_c.delete();
    ov_c.delete(); ov_ch.delete(); or_c.delete(); or_ch.delete();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input logic [NCH-1:0] m);
    req = m; tick(); req = '0;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin tick(); n++; end
    if (n >= budget) chk("idle_timeout", 32'(n), 32'(budget - 1));
    repeat (LAT + 2) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0; tick(); tick(); rst = 1'b1; tick();
    clear_q();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, e0;
    #1 rst = 1'b0;
    repeat (3) tick();
    // reset state
    chk("rst_mac_en",  mac_en, 0);
    chk("rst_busy",    busy, 0);
    chk("rst_ch_sel",  ch_sel, 0);
    chk("rst_tap",     tap_idx, 0);
    chk("rst_outs",    {out_valid, overrun, mac_clr, mac_last}, 0);
    rst = 1'b1;
    tick();

    // ---- single request on ch3 ----
    clear_q(); e0 = en_cnt; c0 = cyc;
    pulse(NCH'(1) << 3);
    wait_idle(100);
    chk("t1_clr_n",    clr_c.size(), 1);
    chk("t1_ch",       qat(clr_ch, 0), 3);
    chk("t1_clr_cyc",  qat(clr_c, 0) - c0, 2);
    chk("t1_last_cyc", qat(last_c, 0) - c0, 12);
    chk("t1_ov_cyc",   qat(ov_c, 0) - c0, 14);
    chk("t1_ov_ch",    qat(ov_ch, 0), 3);
    chk("t1_busy_end", busy_last - c0, 12);
    chk("t1_steps",    en_cnt - e0, NTAPS);

    // ---- all channels at once, from reset (rr=0) ----
    do_reset(); e0 = en_cnt; c0 = cyc;
    pulse('1);
    wait_idle(400);
    chk("t2_clr_n", clr_c.size(), NCH);
    chk("t2_ov_n",  ov_c.size(), NCH);
    chk("t2_or_n",  or_c.size(), 0);
    chk("t2_steps", en_cnt - e0, NCH * NTAPS);
    for (int i = 0; i < NCH; i++) begin
      chk("t2_clr_ch",  qat(clr_ch, i), i);
      chk("t2_clr_cyc", qat(clr_c, i) - c0, 2 + 12 * i);
      chk("t2_ov_ch",   qat(ov_ch, i), i);
      chk("t2_ov_cyc",  qat(ov_c, i) - c0, 14 + 12 * i);
    end

    // ---- round-robin fairness (rr=0 after ch19 wrapped) ----
    clear_q(); pulse(NCH'(1) << 5); wait_idle(100);
    chk("t3_ch5", qat(clr_ch, 0), 5);
    clear_q(); pulse((NCH'(1) << 2) | (NCH'(1) << 7)); wait_idle(100);
    chk("t3_first",  qat(clr_ch, 0), 7);
    chk("t3_second", qat(clr_ch, 1), 2);
    clear_q(); pulse((NCH'(1) << 19) | NCH'(1)); wait_idle(100);
    chk("t3_wrap_a", qat(clr_ch, 0), 19);
    chk("t3_wrap_b", qat(clr_ch, 1), 0);

    // ---- overrun: ch4 requested twice while ch10 runs ----
    clear_q(); c0 = cyc;
    pulse(NCH'(1) << 10);
    run_to(c0 + 3); pulse(NCH'(1) << 4);
    run_to(c0 + 5); pulse(NCH'(1) << 4);
    wait_idle(100);
    chk("t4_or_n",   or_c.size(), 1);
    chk("t4_or_ch",  qat(or_ch, 0), 4);
    chk("t4_or_cyc", qat(or_c, 0) - c0, 6);
    chk("t4_jobs",   clr_c.size(), 2);
    chk("t4_job_a",  qat(clr_ch, 0), 10);
    chk("t4_job_b",  qat(clr_ch, 1), 4);

    // ---- set wins: second ch4 request on its grant cycle ----
    clear_q(); c0 = cyc;
    pulse(NCH'(1) << 4);
    pulse(NCH'(1) << 4);
    wait_idle(100);
    chk("t4b_or_n",  or_c.size(), 0);
    chk("t4b_jobs",  clr_c.size(), 2);
    chk("t4b_ch_b",  qat(clr_ch, 1), 4);
    chk("t4b_cyc_a", qat(clr_c, 0) - c0, 2);
    chk("t4b_cyc_b", qat(clr_c, 1) - c0, 14);

    // ---- stall 3 cycles at tap 5 ----
    clear_q(); e0 = en_cnt; c0 = cyc;
    pulse(NCH'(1) << 6);
    run_to(c0 + 7);
    chk("t5_tap_pre", tap_idx, 5);
    mac_stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("t5_stall_en",  mac_en, 0);
      chk("t5_stall_tap", tap_idx, 5);
      tick();
    end
    mac_stall = 1'b0;
    wait_idle(100);
    chk("t5_last_cyc", qat(last_c, 0) - c0, 15);
    chk("t5_ov_cyc",   qat(ov_c, 0) - c0, 17);
    chk("t5_ov_ch",    qat(ov_ch, 0), 6);
    chk("t5_steps",    en_cnt - e0, NTAPS);

    // ---- reset mid-job with ch1, ch9 pending ----
    clear_q(); c0 = cyc;
    pulse(NCH'(1) << 3);
    run_to(c0 + 3); pulse((NCH'(1) << 1) | (NCH'(1) << 9));
    run_to(c0 + 8);
    chk("t6_tap_pre", tap_idx, 6);
    rst = 1'b0; #1;
    chk("t6_mac_en", mac_en, 0);
    chk("t6_busy",   busy, 0);
    chk("t6_ch_sel", ch_sel, 0);
    chk("t6_tap",    tap_idx, 0);
    chk("t6_out_ch", out_ch, 0);
    clear_q();
    tick(); tick(); rst = 1'b1; tick();
    chk("t6_no_ov", ov_c.size(), 0);
    c0 = cyc;
    pulse(NCH'(1) << 9);
    wait_idle(100);
    chk("t6_jobs",    clr_c.size(), 1);
    chk("t6_ch",      qat(clr_ch, 0), 9);
    chk("t6_clr_cyc", qat(clr_c, 0) - c0, 2);
    chk("t6_ov_n",    ov_c.size(), 1);
    chk("t6_ov_ch",   qat(ov_ch, 0), 9);

    chk("tap_seq_err", tap_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
